// File: rtl/tdc_pkg.sv
// Shared types and helpers for the TDC measurement path.
package tdc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    SAMPLE,
    DONE
  } tdc_state_e;

  // Width of a popcount over an n-bit delay line (0..n inclusive).
  function automatic int unsigned hw_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/tdc_meas_seq_if.sv
// Result channel of the measurement sequencer: valid/ready plus burst statistics.
interface tdc_meas_seq_if #(
  parameter int unsigned HW_W  = tdc_pkg::hw_width(64),
  parameter int unsigned SUM_W = HW_W + 4
);
  logic             res_valid;
  logic             res_ready;
  logic [SUM_W-1:0] res_sum;
  logic [HW_W-1:0]  res_mean;
  logic [HW_W-1:0]  res_min;
  logic [HW_W-1:0]  res_max;

  modport master (
    output res_valid, res_sum, res_mean, res_min, res_max,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_sum, res_mean, res_min, res_max,
    output res_ready
  );
endinterface

// File: rtl/tdc_sample_acc.sv
// Running sum/min/max over captured Hamming weights. The *_o outputs are the
// post-update values, so a consumer can latch a burst's final sample on the same edge.
module tdc_sample_acc #(
  parameter int unsigned HW_W  = 7,
  parameter int unsigned SUM_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             acc_en_i,
  input  logic [HW_W-1:0]  hw_i,
  output logic [SUM_W-1:0] sum_o,
  output logic [HW_W-1:0]  min_o,
  output logic [HW_W-1:0]  max_o
);
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [HW_W-1:0]  min_q, min_d;
  logic [HW_W-1:0]  max_q, max_d;

  always_comb begin
    sum_d = sum_q;
    min_d = min_q;
    max_d = max_q;
    if (clr_i) begin
      sum_d = '0;
      min_d = '1;
      max_d = '0;
    end else if (acc_en_i) begin
      sum_d = sum_q + SUM_W'(hw_i);
      if (hw_i < min_q) min_d = hw_i;
      if (hw_i > max_q) max_d = hw_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      min_q <= '0;
      max_q <= '0;
    end else begin
      sum_q <= sum_d;
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign sum_o = sum_d;
  assign min_o = min_d;
  assign max_o = max_d;

endmodule

// File: rtl/tdc_meas_seq.sv
// Burst measurement sequencer: launches 2^LOG2_SAMPLES edges, captures hw_in LAT
// cycles after each launch and presents sum/mean/min/max over a valid/ready channel.
module tdc_meas_seq
  import tdc_pkg::*;
#(
  parameter int unsigned N            = 64,
  parameter int unsigned LOG2_SAMPLES = 4,
  parameter int unsigned LAT          = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [hw_width(N)-1:0] hw_in,
  output logic                   tdc_en,
  output logic                   pg_tog,
  output logic                   busy,
  tdc_meas_seq_if.master         res
);
  localparam int unsigned HW_W  = hw_width(N);
  localparam int unsigned SUM_W = HW_W + LOG2_SAMPLES;
  localparam int unsigned WCW   = $clog2(LAT + 1);

  localparam logic [LOG2_SAMPLES-1:0] SMP_LAST  = '1;
  localparam logic [WCW-1:0]          WAIT_LOAD = WCW'(LAT - 1);
  localparam logic [WCW-1:0]          WAIT_END  = WCW'(1);

  tdc_state_e state_q, state_d;

  logic [LOG2_SAMPLES-1:0] scnt_q, scnt_d;
  logic [WCW-1:0]          wcnt_q, wcnt_d;

  logic             acc_clr, acc_en, load_res;
  logic [SUM_W-1:0] acc_sum;
  logic [HW_W-1:0]  acc_min, acc_max;

  logic [SUM_W-1:0] res_sum_q;
  logic [HW_W-1:0]  res_mean_q, res_min_q, res_max_q;

  logic res_valid;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; abort has priority over every other request
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (!abort && start) state_d = LAUNCH;
      LAUNCH: begin
        if (abort)        state_d = IDLE;
        else if (LAT > 1) state_d = WAIT;
        else              state_d = SAMPLE;
      end
      WAIT: begin
        if (abort)                   state_d = IDLE;
        else if (wcnt_q == WAIT_END) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (abort)                   state_d = IDLE;
        else if (scnt_q == SMP_LAST) state_d = DONE;
        else                         state_d = LAUNCH;
      end
      DONE:   if (abort || res.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state only
  always_comb begin
    tdc_en    = 1'b0;
    pg_tog    = 1'b0;
    busy      = 1'b1;
    res_valid = 1'b0;
    unique case (state_q)
      IDLE:   busy      = 1'b0;
      LAUNCH: begin
        tdc_en = 1'b1;
        pg_tog = 1'b1;
      end
      WAIT:   tdc_en    = 1'b1;
      SAMPLE: tdc_en    = 1'b1;
      DONE:   res_valid = 1'b1;
      default: busy     = 1'b0;
    endcase
  end

  // Sample and wait counters
  always_comb begin
    scnt_d = scnt_q;
    wcnt_d = wcnt_q;
    if (acc_clr) scnt_d = '0;
    if (state_q == SAMPLE && scnt_q != SMP_LAST) scnt_d = scnt_q + 1'b1;
    if (state_q == LAUNCH) wcnt_d = WAIT_LOAD;
    if (state_q == WAIT)   wcnt_d = wcnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scnt_q <= '0;
      wcnt_q <= '0;
    end else begin
      scnt_q <= scnt_d;
      wcnt_q <= wcnt_d;
    end
  end

  assign acc_clr  = (state_q == IDLE) && start && !abort;
  assign acc_en   = (state_q == SAMPLE);
  assign load_res = (state_q == SAMPLE) && !abort && (scnt_q == SMP_LAST);

  tdc_sample_acc #(
    .HW_W  (HW_W),
    .SUM_W (SUM_W)
  ) u_acc (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (acc_clr),
    .acc_en_i (acc_en),
    .hw_i     (hw_in),
    .sum_o    (acc_sum),
    .min_o    (acc_min),
    .max_o    (acc_max)
  );

  // Results latch the post-update accumulator on the edge that enters DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      res_sum_q  <= '0;
      res_mean_q <= '0;
      res_min_q  <= '0;
      res_max_q  <= '0;
    end else if (load_res) begin
      res_sum_q  <= acc_sum;
      res_mean_q <= acc_sum[SUM_W-1:LOG2_SAMPLES];
      res_min_q  <= acc_min;
      res_max_q  <= acc_max;
    end
  end

  assign res.res_valid = res_valid;
  assign res.res_sum   = res_sum_q;
  assign res.res_mean  = res_mean_q;
  assign res.res_min   = res_min_q;
  assign res.res_max   = res_max_q;

endmodule
